host_reg_responder: RTL and testbench
=====================================

Name: host_reg_responder

Overview:
- Responder side of the host register-bridge transaction. The host initiates 32-bit register reads and writes; this block decodes them against a small register map and returns read data through a fixed-latency valid pipeline.
- It replaces ad-hoc per-endpoint wiring. The map holds LED control, two operands with a registered sum, button status, access counters, a command pulse and a sticky decode-error flag.
- It sits between the host bridge output and the board I/O (LEDs, buttons).

Parameters:
- RD_LATENCY, 2, cycles from reg_read to reg_rvalid; legal range 1..4.
- LED_WIDTH, 6, number of LED outputs driven from CTRL[LED_WIDTH-1:0].
- BTN_WIDTH, 4, number of button inputs reported in STATUS[BTN_WIDTH-1:0].

Ports:
- okClk  in  1  sole clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- reg_addr  in  32  register address; only [7:0] is decoded, [31:8] must be 0 or the access is unmapped
- reg_wdata  in  32  write data
- reg_write  in  1  one-cycle write strobe
- reg_read  in  1  one-cycle read strobe
- reg_rdata  out  32  read data; valid only when reg_rvalid=1, otherwise 0
- reg_rvalid  out  1  one-cycle pulse, one per accepted read
- led  out  LED_WIDTH  equals CTRL[LED_WIDTH-1:0]
- btn  in  BTN_WIDTH  asynchronous buttons; pass through a 2-FF synchronizer before use
- trig_pulse  out  1  one-cycle pulse on a CMD write with bit1=1

Behaviour:
- Reset (async assert, released synchronously to okClk): every register is 0, including CTRL, OPA, OPB, SUM, WRCNT, RDCNT, err_sticky, the synchronizer flops and the read pipeline. Outputs are reg_rvalid=0, reg_rdata=0, led=0, trig_pulse=0. A reset mid-read drops all in-flight reads with no rvalid.
- Register map:
  - 0x00 CTRL: RW, 32 bits.
  - 0x01 OPA: RW.
  - 0x02 OPB: RW.
  - 0x03 CMD: WO, reads 0. bit0=1 clears WRCNT, RDCNT and err_sticky. bit1=1 raises trig_pulse the cycle after the write.
  - 0x20 STATUS: RO. [BTN_WIDTH-1:0]=synchronized btn, [16]=sum_carry, [31]=err_sticky, other bits 0.
  - 0x21 SUM: RO, OPA+OPB mod 2^32; sum_carry is bit 32 of that addition.
  - 0x22 WRCNT: RO, accepted writes, wraps at 2^32.
  - 0x23 RDCNT: RO, accepted reads, wraps at 2^32.
- Write timing: a write in cycle N updates the target register at the edge ending cycle N. SUM and sum_carry recompute every cycle from the registered OPA and OPB, so they reflect a write in cycle N at the edge ending N+1.
- Reads are sampled at the edge ending the strobe cycle and emerge RD_LATENCY cycles later. A read in cycle N produces reg_rvalid high in cycle N+RD_LATENCY. One read per cycle is sustained, fully pipelined, with no stalls. The host has no back-pressure.
- Simultaneous reg_read and reg_write in the same cycle: both are accepted, and the read returns the pre-write value even at the same address.
- Read of SUM in cycle N+1 after an OPA write in N returns the old sum; a read in N+2 returns the new sum.
- Unmapped access, meaning an unlisted address, [31:8] nonzero, a write to RO or a read of CMD:
  - write: discarded; sets err_sticky; still counted in WRCNT.
  - read: returns 0; sets err_sticky; still counted in RDCNT.
  - A read of CMD returns 0 and sets err_sticky.
- A CMD write with bit0=1 clears WRCNT to 0, overriding that write's own increment. It also overrides any simultaneous read increment and error set, so counters and err_sticky are all 0 afterwards.
- Counter width rule: WRCNT and RDCNT increment by 1 per accepted strobe, and 0xFFFF_FFFF wraps to 0.
- No internal state machine beyond the pipeline; the block is a registered decoder.

Decomposition:
- Shared package host_reg_pkg holds:
  - address constants ADDR_CTRL..ADDR_RDCNT
  - CMD bit indices CMD_CLR=0 and CMD_TRIG=1
  - STATUS bit indices ST_CARRY=16 and ST_ERR=31
  - RD_LATENCY legal bounds
- One sub-module, reg_rd_pipe, is a parameterized valid/data shift register of depth RD_LATENCY with async reset. It carries {valid, data} so that reg_rdata is 0 whenever valid is 0.

Test Plan:
- Reset then read 0x00, 0x21, 0x22 back-to-back -> three rvalid pulses at cycles 2, 3, 4 after the first strobe (RD_LATENCY=2), all data 0. Then RDCNT=3 on a fourth read.
- Write OPA=0xFFFF_FFFF, OPB=0x0000_0002, then read SUM and STATUS two cycles later -> SUM=0x0000_0001, STATUS[16]=1, STATUS[31]=0.
- Same-cycle write CTRL=0x3F and read CTRL from reset -> returned data 0, led=6'h3F; a next read returns 0x0000_003F.
- Write 0x05 and read 0x100 -> err_sticky=1 (STATUS=0x8000_0000 with btn=0), reads return 0. Then CMD write 0x1 -> WRCNT, RDCNT and err_sticky read 0.
- CMD write 0x2 -> trig_pulse high exactly one cycle, the cycle after the write. Drive btn=4'b1010 -> STATUS[3:0]=4'hA after 2 cycles of sync plus the read latency.
- Assert reset with 2 reads in flight -> no rvalid follows, and all registers read 0 after release.

Source files
------------

// File: rtl/host_reg_pkg.sv
// Shared address map, command/status bit positions and read-latency bounds
// for the host register responder.
package host_reg_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_OPA    = 8'h01;
  localparam logic [7:0] ADDR_OPB    = 8'h02;
  localparam logic [7:0] ADDR_CMD    = 8'h03;
  localparam logic [7:0] ADDR_STATUS = 8'h20;
  localparam logic [7:0] ADDR_SUM    = 8'h21;
  localparam logic [7:0] ADDR_WRCNT  = 8'h22;
  localparam logic [7:0] ADDR_RDCNT  = 8'h23;

  localparam int CMD_CLR  = 0;
  localparam int CMD_TRIG = 1;

  localparam int ST_CARRY = 16;
  localparam int ST_ERR   = 31;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/reg_rd_pipe.sv
// Fixed-depth valid/data shift register for read returns; data is forced
// to zero on entry whenever valid is low, so the output is 0 when idle.
module reg_rd_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic         vld_p  [DEPTH];
  logic [W-1:0] data_p [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_p[i]  <= 1'b0;
        data_p[i] <= '0;
      end
    end else begin
      vld_p[0]  <= in_vld;
      data_p[0] <= in_vld ? in_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i]  <= vld_p[i-1];
        data_p[i] <= data_p[i-1];
      end
    end
  end

  assign out_vld  = vld_p[DEPTH-1];
  assign out_data = data_p[DEPTH-1];

endmodule

// File: rtl/host_reg_responder.sv
// Registered decoder for host register reads/writes: LED control, operand
// adder, button status, access counters, command pulse and sticky error.
module host_reg_responder
  import host_reg_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int LED_WIDTH  = 6,
  parameter int BTN_WIDTH  = 4
) (
  input  logic                 okClk,
  input  logic                 reset,
  input  logic [31:0]          reg_addr,
  input  logic [31:0]          reg_wdata,
  input  logic                 reg_write,
  input  logic                 reg_read,
  output logic [31:0]          reg_rdata,
  output logic                 reg_rvalid,
  output logic [LED_WIDTH-1:0] led,
  input  logic [BTN_WIDTH-1:0] btn,
  output logic                 trig_pulse
);

  logic [31:0]          ctrl, opa, opb, wrcnt, rdcnt;
  logic [32:0]          sum_q;
  logic                 err_sticky;
  logic [BTN_WIDTH-1:0] btn_p0, btn_p1;

  logic                 addr_ok;
  logic [7:0]           off;
  logic                 wr_ctrl, wr_opa, wr_opb, wr_cmd, wr_err;
  logic                 rd_err;
  logic                 clr;
  logic [31:0]          status, rd_data;

  assign addr_ok = (reg_addr[31:8] == 24'd0);
  assign off     = reg_addr[7:0];

  always_comb begin
    wr_ctrl = 1'b0;
    wr_opa  = 1'b0;
    wr_opb  = 1'b0;
    wr_cmd  = 1'b0;
    wr_err  = 1'b0;
    if (reg_write) begin
      if (!addr_ok) wr_err = 1'b1;
      else begin
        unique case (off)
          ADDR_CTRL: wr_ctrl = 1'b1;
          ADDR_OPA:  wr_opa  = 1'b1;
          ADDR_OPB:  wr_opb  = 1'b1;
          ADDR_CMD:  wr_cmd  = 1'b1;
          default:   wr_err  = 1'b1;
        endcase
      end
    end
  end

  assign clr = wr_cmd & reg_wdata[CMD_CLR];

  always_comb begin
    status                  = '0;
    status[BTN_WIDTH-1:0]   = btn_p1;
    status[ST_CARRY]        = sum_q[32];
    status[ST_ERR]          = err_sticky;
  end

  // Read mux sees pre-write state, so a same-cycle write is never visible.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (reg_read) begin
      if (!addr_ok) rd_err = 1'b1;
      else begin
        unique case (off)
          ADDR_CTRL:   rd_data = ctrl;
          ADDR_OPA:    rd_data = opa;
          ADDR_OPB:    rd_data = opb;
          ADDR_STATUS: rd_data = status;
          ADDR_SUM:    rd_data = sum_q[31:0];
          ADDR_WRCNT:  rd_data = wrcnt;
          ADDR_RDCNT:  rd_data = rdcnt;
          default:     rd_err  = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      ctrl       <= '0;
      opa        <= '0;
      opb        <= '0;
      sum_q      <= '0;
      wrcnt      <= '0;
      rdcnt      <= '0;
      err_sticky <= 1'b0;
      trig_pulse <= 1'b0;
      btn_p0     <= '0;
      btn_p1     <= '0;
    end else begin
      btn_p0     <= btn;
      btn_p1     <= btn_p0;
      sum_q      <= {1'b0, opa} + {1'b0, opb};
      trig_pulse <= wr_cmd & reg_wdata[CMD_TRIG];
      if (wr_ctrl) ctrl <= reg_wdata;
      if (wr_opa)  opa  <= reg_wdata;
      if (wr_opb)  opb  <= reg_wdata;
      // A clear command wins over this cycle's own increments and error set.
      if (clr) begin
        wrcnt      <= '0;
        rdcnt      <= '0;
        err_sticky <= 1'b0;
      end else begin
        if (reg_write) wrcnt <= wrcnt + 32'd1;
        if (reg_read)  rdcnt <= rdcnt + 32'd1;
        if (wr_err || rd_err) err_sticky <= 1'b1;
      end
    end
  end

  assign led = ctrl[LED_WIDTH-1:0];

  reg_rd_pipe #(
    .DEPTH (RD_LATENCY),
    .W     (32)
  ) u_rd_pipe (
    .clk      (okClk),
    .rst      (reset),
    .in_vld   (reg_read),
    .in_data  (rd_data),
    .out_vld  (reg_rvalid),
    .out_data (reg_rdata)
  );

endmodule

// File: tb/tb_host_reg_responder.sv
// Directed plus randomized bench for host_reg_responder against a
// register-map reference model with a queue of pending read returns.
module tb_host_reg_responder;

  localparam int LAT = 2;

  logic        okClk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic        reg_write = 1'b0;
  logic        reg_read = 1'b0;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic [5:0]  led;
  logic [3:0]  btn = '0;
  logic        trig_pulse;

  host_reg_responder #(.RD_LATENCY(LAT), .LED_WIDTH(6), .BTN_WIDTH(4)) dut (
    .okClk      (okClk),
    .reset      (reset),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_write  (reg_write),
    .reg_read   (reg_read),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .led        (led),
    .btn        (btn),
    .trig_pulse (trig_pulse)
  );

  always #5 okClk = ~okClk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  rd_t         q[$];
  logic [31:0] m_ctrl, m_opa, m_opb, m_wrcnt, m_rdcnt;
  logic [32:0] m_sum;
  logic        m_err, m_trig;
  logic [3:0]  b_m1, b_m2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    if (a[31:8] != 24'd0) return -1;
    case (a[7:0])
      8'h00: return 0;
      8'h01: return 1;
      8'h02: return 2;
      8'h03: return 3;
      8'h20: return 4;
      8'h21: return 5;
      8'h22: return 6;
      8'h23: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int id);
    case (id)
      0: return m_ctrl;
      1: return m_opa;
      2: return m_opb;
      4: return {m_err, 14'd0, m_sum[32], 12'd0, b_m2};
      5: return m_sum[31:0];
      6: return m_wrcnt;
      7: return m_rdcnt;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    m_ctrl = '0; m_opa = '0; m_opb = '0; m_wrcnt = '0; m_rdcnt = '0;
    m_sum = '0; m_err = 1'b0; m_trig = 1'b0; b_m1 = '0; b_m2 = '0;
    q.delete();
  endtask

  task automatic step(input logic wr, input logic rd, input logic [31:0] addr,
                      input logic [31:0] wdata);
    int          id;
    logic        clr, bad_wr, bad_rd;
    logic [32:0] next_sum;
    logic        ev;
    logic [31:0] ed;
    rd_t         r;
    reg_write = wr; reg_read = rd; reg_addr = addr; reg_wdata = wdata;
    id       = decode(addr);
    next_sum = {1'b0, m_opa} + {1'b0, m_opb};
    bad_wr   = wr && (id < 0 || id >= 4);
    bad_rd   = rd && (id < 0 || id == 3);
    clr      = wr && id == 3 && wdata[0];
    if (rd) begin
      r.due = cyc + LAT; r.data = model_read(id); q.push_back(r);
    end
    if (wr && id == 0) m_ctrl = wdata;
    if (wr && id == 1) m_opa = wdata;
    if (wr && id == 2) m_opb = wdata;
    m_trig = wr && id == 3 && wdata[1];
    if (clr) begin
      m_wrcnt = 0; m_rdcnt = 0; m_err = 1'b0;
    end else begin
      if (wr) m_wrcnt = m_wrcnt + 1;
      if (rd) m_rdcnt = m_rdcnt + 1;
      if (bad_wr || bad_rd) m_err = 1'b1;
    end
    m_sum = next_sum;
    b_m2  = b_m1;
    b_m1  = btn;
    @(posedge okClk); #1;
    cyc++;
    reg_write = 1'b0; reg_read = 1'b0;
    ev = 1'b0; ed = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev = 1'b1; ed = q[0].data; void'(q.pop_front());
    end
    chk("rvalid", {31'd0, reg_rvalid}, {31'd0, ev});
    chk("rdata", reg_rdata, ed);
    chk("led", {26'd0, led}, {26'd0, m_ctrl[5:0]});
    chk("trig_pulse", {31'd0, trig_pulse}, {31'd0, m_trig});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_rvalid", {31'd0, reg_rvalid}, 32'd0);
    chk("rst_rdata", reg_rdata, 32'd0);
    chk("rst_led", {26'd0, led}, 32'd0);
    chk("rst_trig", {31'd0, trig_pulse}, 32'd0);
    model_clear();
    @(posedge okClk); #1; cyc++;
    @(posedge okClk); #1; cyc++;
    reset = 1'b0;
  endtask

  logic [31:0] alist [12];

  initial begin
    alist = '{32'h00, 32'h01, 32'h02, 32'h03, 32'h20, 32'h21, 32'h22, 32'h23,
              32'h05, 32'h100, 32'h24, 32'h8000_0001};
    model_clear();
    apply_reset();

    // back-to-back reads from reset, then RDCNT
    rd(32'h00); rd(32'h21); rd(32'h22); rd(32'h23);
    idle(3);

    // operand carry-out
    wr(32'h01, 32'hFFFF_FFFF); wr(32'h02, 32'h0000_0002);
    idle(1);
    rd(32'h21); rd(32'h20);
    idle(3);

    // same-cycle write and read of CTRL from reset
    apply_reset();
    step(1'b1, 1'b1, 32'h00, 32'h0000_003F);
    rd(32'h00);
    idle(3);

    // unmapped accesses, then clear command
    wr(32'h05, 32'h1234_5678); rd(32'h100); rd(32'h20); rd(32'h03);
    idle(3);
    wr(32'h03, 32'h1);
    rd(32'h22); rd(32'h23); rd(32'h20);
    idle(3);

    // trigger pulse and button synchronizer
    wr(32'h03, 32'h2);
    idle(2);
    btn = 4'b1010;
    idle(2);
    rd(32'h20);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic        w, r;
      logic [31:0] a, d;
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 1) == 0);
      a = alist[$urandom_range(0, 11)];
      d = $urandom;
      if (decode(a) == 3 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      if ($urandom_range(0, 7) == 0) btn = 4'($urandom);
      step(w, r, a, d);
    end
    idle(LAT + 2);

    // reset with reads in flight, then every register reads 0
    rd(32'h00); rd(32'h01);
    apply_reset();
    idle(LAT + 1);
    for (int i = 0; i < 8; i++) rd(alist[i]);
    idle(LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
